// File: rtl/interrupt_entry_sequencer.sv
// Hardware interrupt entry: drain the pipeline, push the resume PC (high word,
// then low word) and the flags onto the stack, fetch the two-word service
// routine address from the vector in data memory and load it into the PC.
// The front end is held stalled for the whole sequence.
module interrupt_entry_sequencer #(
  parameter int PC_WIDTH     = 32,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 12,
  parameter int FLAG_WIDTH   = 3,
  parameter int DRAIN_CYCLES = 3,
  parameter int VECTOR_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  intr_req,
  input  logic [PC_WIDTH-1:0]   pc_in,
  input  logic [FLAG_WIDTH-1:0] flags_in,
  input  logic [ADDR_WIDTH-1:0] sp_in,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  stall,
  output logic                  flush,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  sp_dec,
  output logic                  flags_clr,
  output logic                  pc_we,
  output logic [PC_WIDTH-1:0]   pc_out
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);
  // Vector low word sits one above the high word; the add wraps at the address width.
  localparam logic [ADDR_WIDTH-1:0] VEC_HI_ADDR = ADDR_WIDTH'(VECTOR_ADDR);
  localparam logic [ADDR_WIDTH-1:0] VEC_LO_ADDR = VEC_HI_ADDR + ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    PUSH_HI,
    PUSH_LO,
    PUSH_FLG,
    RD_HI,
    RD_LO,
    LOAD
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic                    pending_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [PC_WIDTH-1:0]     pc_lat_q;
  logic [FLAG_WIDTH-1:0]   flg_lat_q;
  logic [DATA_WIDTH-1:0]   vec_hi_q;
  logic                    accept;

  // A new sequence starts only from IDLE, for a live pulse or a remembered one.
  assign accept = (state_q == IDLE) && (intr_req || pending_q);

  assign busy  = (state_q != IDLE);
  assign stall = busy;

  // Control state: FSM register, one-deep pending request, drain counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pending_q <= 1'b0;
        cnt_q     <= CNT_INIT;
      end else begin
        // Requests seen while busy (including a held pulse) merge into one.
        if ((state_q != IDLE) && intr_req) pending_q <= 1'b1;
        if ((state_q == DRAIN) && (cnt_q != '0)) cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Captured context: resume PC and flags at acceptance, vector high word at RD_LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_lat_q  <= '0;
      flg_lat_q <= '0;
      vec_hi_q  <= '0;
    end else begin
      if (accept) begin
        pc_lat_q  <= pc_in;
        flg_lat_q <= flags_in;
      end
      // Read data of the RD_HI access arrives during RD_LO.
      if (state_q == RD_LO) vec_hi_q <= mem_rdata;
    end
  end

  // Next-state and strobe decode; every output idles at zero.
  always_comb begin
    state_d   = state_q;
    flush     = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    sp_dec    = 1'b0;
    flags_clr = 1'b0;
    pc_we     = 1'b0;
    pc_out    = '0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = DRAIN;
      end
      DRAIN: begin
        // The counter only moves down, so its load value marks the first cycle.
        flush = (cnt_q == CNT_INIT);
        if (cnt_q == '0) state_d = PUSH_HI;
      end
      PUSH_HI: begin
        mem_we    = 1'b1;
        mem_addr  = sp_in;
        mem_wdata = pc_lat_q[PC_WIDTH-1:DATA_WIDTH];
        sp_dec    = 1'b1;
        state_d   = PUSH_LO;
      end
      PUSH_LO: begin
        mem_we    = 1'b1;
        mem_addr  = sp_in;
        mem_wdata = pc_lat_q[DATA_WIDTH-1:0];
        sp_dec    = 1'b1;
        state_d   = PUSH_FLG;
      end
      PUSH_FLG: begin
        mem_we    = 1'b1;
        mem_addr  = sp_in;
        mem_wdata = DATA_WIDTH'(flg_lat_q);
        sp_dec    = 1'b1;
        flags_clr = 1'b1;
        state_d   = RD_HI;
      end
      RD_HI: begin
        mem_re   = 1'b1;
        mem_addr = VEC_HI_ADDR;
        state_d  = RD_LO;
      end
      RD_LO: begin
        mem_re   = 1'b1;
        mem_addr = VEC_LO_ADDR;
        state_d  = LOAD;
      end
      LOAD: begin
        pc_we   = 1'b1;
        pc_out  = {vec_hi_q, mem_rdata};
        flush   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
